// File: rtl/soc_system_sample_fifo.sv
// Single-clock first-word-fall-through sample FIFO with fill level, almost-full and sticky overflow.
// The fill level is a separate counter so that full (usedw == DEPTH) is distinguished from empty when the pointers are equal.
module soc_system_sample_fifo #(
    parameter int DATA_W   = 32,
    parameter int DEPTH    = 1024,
    parameter int ADDR_W   = 10,
    parameter int AF_LEVEL = 896
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              sclr,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [15:0]       usedw,
    output logic              full,
    output logic              almost_full,
    output logic              overflow,
    input  logic              clr_overflow
);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [ADDR_W-1:0] r_wr_ptr;
    logic [ADDR_W-1:0] r_rd_ptr;
    logic [15:0]       r_usedw;
    logic              r_full;
    logic              r_almost_full;
    logic              r_out_valid;
    logic              r_in_ready;
    logic              r_overflow;

    logic              w_push;
    logic              w_pop;
    logic [15:0]       w_usedw_nxt;

    // sclr masks both handshakes so a flush cycle neither stores nor consumes data
    assign w_push = in_valid & r_in_ready & ~sclr;
    assign w_pop  = r_out_valid & out_ready & ~sclr;

    always_comb begin
        w_usedw_nxt = r_usedw;
        if (sclr) begin
            w_usedw_nxt = 16'd0;
        end else if (w_push && !w_pop) begin
            w_usedw_nxt = r_usedw + 16'd1;
        end else if (w_pop && !w_push) begin
            w_usedw_nxt = r_usedw - 16'd1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_ptr      <= '0;
            r_rd_ptr      <= '0;
            r_usedw       <= 16'd0;
            r_full        <= 1'b0;
            r_almost_full <= 1'b0;
            r_out_valid   <= 1'b0;
            r_in_ready    <= 1'b1;
        end else begin
            if (sclr) begin
                r_wr_ptr <= '0;
                r_rd_ptr <= '0;
            end else begin
                if (w_push) r_wr_ptr <= r_wr_ptr + ADDR_W'(1);
                if (w_pop)  r_rd_ptr <= r_rd_ptr + ADDR_W'(1);
            end
            r_usedw       <= w_usedw_nxt;
            r_full        <= (w_usedw_nxt == 16'(DEPTH));
            r_almost_full <= (w_usedw_nxt >= 16'(AF_LEVEL));
            r_out_valid   <= (w_usedw_nxt != 16'd0);
            r_in_ready    <= (w_usedw_nxt != 16'(DEPTH));
        end
    end

    // A push attempt against a full FIFO wins over a same-cycle clear; a flush cycle never counts as an attempt
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_overflow <= 1'b0;
        end else if (in_valid && r_full && !sclr) begin
            r_overflow <= 1'b1;
        end else if (clr_overflow) begin
            r_overflow <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= in_data;
    end

    // Head word is read straight from storage; it cannot change under a stalled consumer
    // because the write pointer never equals the read pointer while data is held and space remains.
    assign out_data    = r_out_valid ? r_mem[r_rd_ptr] : '0;
    assign out_valid   = r_out_valid;
    assign in_ready    = r_in_ready;
    assign usedw       = r_usedw;
    assign full        = r_full;
    assign almost_full = r_almost_full;
    assign overflow    = r_overflow;

endmodule

// File: tb/tb_soc_system_sample_fifo.sv
// Directed testbench for soc_system_sample_fifo with DEPTH=1024, AF_LEVEL=896.
module tb_soc_system_sample_fifo;

    logic        clk;
    logic        reset_n;
    logic        sclr;
    logic [31:0] in_data;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] out_data;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] usedw;
    logic        full;
    logic        almost_full;
    logic        overflow;
    logic        clr_overflow;

    int total = 0;
    int bad   = 0;

    soc_system_sample_fifo #(
        .DATA_W(32), .DEPTH(1024), .ADDR_W(10), .AF_LEVEL(896)
    ) dut (
        .clk(clk), .reset_n(reset_n), .sclr(sclr),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .usedw(usedw), .full(full), .almost_full(almost_full),
        .overflow(overflow), .clr_overflow(clr_overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        in_valid = 0; out_ready = 0; sclr = 0; clr_overflow = 0; in_data = 0;
        reset_n = 0;
        tick();
        tick();
        reset_n = 1;
        tick();
    endtask

    task automatic push_n(input int n, input int base);
        for (int i = 0; i < n; i++) begin
            in_data = base + i; in_valid = 1;
            tick();
        end
        in_valid = 0;
    endtask

    task automatic test_reset();
        do_reset();
        total++; if (usedw !== 16'd0) begin bad++; $display("FAIL reset_usedw got=%0d exp=0", usedw); end
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
        total++; if ({full, almost_full, overflow} !== 3'b000) begin bad++; $display("FAIL reset_flags got=%b exp=000", {full, almost_full, overflow}); end
        total++; if (out_data !== 32'h0) begin bad++; $display("FAIL reset_out_data got=%h exp=0", out_data); end
    endtask

    task automatic test_single();
        do_reset();
        in_data = 32'hA5A5_0001; in_valid = 1;
        tick();
        in_valid = 0;
        total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL single_valid got=%b exp=1", out_valid); end
        total++; if (out_data !== 32'hA5A5_0001) begin bad++; $display("FAIL single_data got=%h exp=a5a50001", out_data); end
        total++; if (usedw !== 16'd1) begin bad++; $display("FAIL single_usedw got=%0d exp=1", usedw); end
        tick();
        total++; if (out_data !== 32'hA5A5_0001) begin bad++; $display("FAIL single_hold got=%h exp=a5a50001", out_data); end
        out_ready = 1;
        tick();
        total++; if (usedw !== 16'd0) begin bad++; $display("FAIL single_pop_usedw got=%0d exp=0", usedw); end
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL single_pop_valid got=%b exp=0", out_valid); end
        tick();
        out_ready = 0;
        total++; if (usedw !== 16'd0) begin bad++; $display("FAIL empty_pop_usedw got=%0d exp=0", usedw); end
    endtask

    task automatic test_fill();
        do_reset();
        for (int i = 0; i < 1024; i++) begin
            in_data = i; in_valid = 1;
            tick();
            if (i == 894) begin
                total++; if (almost_full !== 1'b0) begin bad++; $display("FAIL af_895 got=%b exp=0", almost_full); end
            end
            if (i == 895) begin
                total++; if (almost_full !== 1'b1) begin bad++; $display("FAIL af_896 got=%b exp=1", almost_full); end
            end
            if (i == 1022) begin
                total++; if (full !== 1'b0) begin bad++; $display("FAIL full_1023 got=%b exp=0", full); end
            end
        end
        total++; if (usedw !== 16'd1024) begin bad++; $display("FAIL fill_usedw got=%0d exp=1024", usedw); end
        total++; if (full !== 1'b1 || in_ready !== 1'b0) begin bad++; $display("FAIL fill_full got=%b/%b exp=1/0", full, in_ready); end
        total++; if (overflow !== 1'b0) begin bad++; $display("FAIL fill_no_ovf got=%b exp=0", overflow); end
        in_data = 32'hDEAD_BEEF; clr_overflow = 1;
        tick();
        in_valid = 0; clr_overflow = 0;
        total++; if (overflow !== 1'b1) begin bad++; $display("FAIL ovf_set got=%b exp=1", overflow); end
        total++; if (usedw !== 16'd1024) begin bad++; $display("FAIL ovf_usedw got=%0d exp=1024", usedw); end
    endtask

    // Starts full: the first cycle is pop-only, after which in_ready returns and push+pop balance.
    task automatic test_full_push_pop();
        in_valid = 1; out_ready = 1;
        for (int k = 0; k < 10; k++) begin
            in_data = 2000 + k;
            total++; if (out_data !== k) begin bad++; $display("FAIL fpp_data%0d got=%0d exp=%0d", k, out_data, k); end
            tick();
            if (k == 0) begin
                total++; if (usedw !== 16'd1023) begin bad++; $display("FAIL fpp_first got=%0d exp=1023", usedw); end
            end
        end
        in_valid = 0; out_ready = 0;
        total++; if (usedw !== 16'd1023) begin bad++; $display("FAIL fpp_usedw got=%0d exp=1023", usedw); end
        total++; if (out_data !== 32'd10) begin bad++; $display("FAIL fpp_head got=%0d exp=10", out_data); end
    endtask

    task automatic test_back_to_back();
        int errs;
        do_reset();
        push_n(5, 0);
        errs = 0;
        in_valid = 1; out_ready = 1;
        for (int k = 0; k < 3000; k++) begin
            in_data = 5 + k;
            if (out_data !== k) errs++;
            tick();
            if (usedw !== 16'd5) errs++;
        end
        in_valid = 0; out_ready = 0;
        total++; if (errs != 0) begin bad++; $display("FAIL b2b_stream errors got=%0d exp=0", errs); end
        total++; if (out_data !== 32'd3000) begin bad++; $display("FAIL b2b_head got=%0d exp=3000", out_data); end
    endtask

    task automatic test_sclr();
        do_reset();
        push_n(1025, 0);
        out_ready = 1;
        for (int k = 0; k < 724; k++) tick();
        out_ready = 0;
        total++; if (usedw !== 16'd300 || overflow !== 1'b1) begin bad++; $display("FAIL sclr_pre got=%0d/%b exp=300/1", usedw, overflow); end
        sclr = 1; in_valid = 1; in_data = 32'h5555;
        tick();
        sclr = 0; in_valid = 0;
        total++; if (usedw !== 16'd0) begin bad++; $display("FAIL sclr_usedw got=%0d exp=0", usedw); end
        total++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin bad++; $display("FAIL sclr_flags got=%b/%b exp=0/1", out_valid, in_ready); end
        total++; if (overflow !== 1'b1) begin bad++; $display("FAIL sclr_ovf got=%b exp=1", overflow); end
        clr_overflow = 1;
        tick();
        clr_overflow = 0;
        total++; if (overflow !== 1'b0) begin bad++; $display("FAIL clr_ovf got=%b exp=0", overflow); end
    endtask

    task automatic test_async_reset();
        do_reset();
        for (int i = 0; i < 77; i++) begin
            in_data = 100 + i; in_valid = 1;
            tick();
        end
        total++; if (usedw !== 16'd77) begin bad++; $display("FAIL ar_pre got=%0d exp=77", usedw); end
        #2;
        reset_n = 0;
        #1;
        total++; if (usedw !== 16'd0 || out_valid !== 1'b0 || out_data !== 32'h0) begin bad++; $display("FAIL ar_immediate got=%0d/%b/%h exp=0/0/0", usedw, out_valid, out_data); end
        total++; if (in_ready !== 1'b1 || full !== 1'b0 || almost_full !== 1'b0) begin bad++; $display("FAIL ar_flags got=%b/%b/%b exp=1/0/0", in_ready, full, almost_full); end
        in_valid = 0;
        tick();
        reset_n = 1;
        tick();
        in_data = 32'h1234; in_valid = 1;
        tick();
        in_valid = 0;
        total++; if (out_data !== 32'h1234 || usedw !== 16'd1) begin bad++; $display("FAIL ar_first got=%h/%0d exp=1234/1", out_data, usedw); end
    endtask

    initial begin
        reset_n = 0; sclr = 0; in_data = 0; in_valid = 0; out_ready = 0; clr_overflow = 0;
        test_reset();
        test_single();
        test_fill();
        test_full_push_pop();
        test_back_to_back();
        test_sclr();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
